// File: rtl/cpu_types_pkg.sv
// Shared encodings for the memory arbiter: RAM port status and arbiter FSM states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IACC = 2'd1;
  localparam logic [1:0] ST_DACC = 2'd2;

  localparam int WORD_W = 32;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the instruction, data and RAM-side signals around the memory arbiter.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              iwait;
  logic              dwait;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;

  // Handshake: a requester holds its REN/WEN, address and store data steady
  // until its wait flag is sampled low; that cycle is the one and only
  // completion, and load data is valid only in that cycle.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/arb_starve_counter.sv
// Counts data grants completed while an instruction fetch waits; flags starvation at STARVE_MAX.
module arb_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic instr_req,
  input  logic instr_done,
  input  logic data_done,
  output logic starved
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (!instr_req || instr_done) begin
      count <= '0;
    end else if (data_done && count != CW'(STARVE_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign starved = (count == CW'(STARVE_MAX));
endmodule

// File: rtl/memory_arbiter.sv
// Two-requester (instruction/data) arbiter onto a single RAM port; data wins by default.
// Optional fairness guard enabled with `define ARB_STARVE_GUARD_EN.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  memory_arbiter_if.slave     bus,
  output logic [1:0]          state
);
  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic              dreq, access, active;
  logic              i_done, d_done, starved;

  assign dreq   = bus.dREN | bus.dWEN;
  assign access = (bus.ramstate == ACCESS);
  assign active = (state_q != ST_IDLE);
  // A completion needs the owner still requesting; a dropped request aborts instead.
  assign i_done = (state_q == ST_IACC) && bus.iREN && access;
  assign d_done = (state_q == ST_DACC) && dreq && access;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.iREN && (starved || !dreq)) begin
          state_d = ST_IACC;
          addr_d  = bus.iaddr;
          store_d = '0;
          ren_d   = 1'b1;
          wen_d   = 1'b0;
        end else if (dreq) begin
          state_d = ST_DACC;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          ren_d   = ~bus.dWEN;
          wen_d   = bus.dWEN;
        end
      end
      ST_IACC: if (!bus.iREN || access) state_d = ST_IDLE;
      ST_DACC: if (!dreq || access) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      store_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .CLK        (CLK),
    .nRST       (nRST),
    .instr_req  (bus.iREN),
    .instr_done (i_done),
    .data_done  (d_done),
    .starved    (starved)
  );
`else
  assign starved = 1'b0;
`endif

  // The RAM only ever sees the latched request, never the live inputs.
  assign bus.ramREN   = active & ren_q;
  assign bus.ramWEN   = active & wen_q;
  assign bus.ramaddr  = active ? addr_q  : '0;
  assign bus.ramstore = active ? store_q : '0;

  assign bus.iwait = ~i_done;
  assign bus.dwait = ~d_done;
  assign bus.iload = i_done ? bus.ramload : '0;
  assign bus.dload = d_done ? bus.ramload : '0;

  assign state = state_q;
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: max consecutive data grants while an instruction request waits.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports iREN input 1 and iaddr input 32: instruction-fetch read request and word address.
REQ-005 SHALL have ports dREN input 1, dWEN input 1, daddr input 32 and dstore input 32: data read/write request, address and write data.
REQ-006 SHALL have ports iwait output 1, dwait output 1, iload output 32 and dload output 32: per-requester stall flags and read data.
REQ-007 SHALL have ports ramREN output 1, ramWEN output 1, ramaddr output 32 and ramstore output 32: the single RAM port.
REQ-008 SHALL have ports ramload input 32 and ramstate input 2: read data and status (FREE=0, BUSY=1, ACCESS=2, ERROR=3).

Function
REQ-009 SHALL implement an FSM with states IDLE, IACC, DACC.
REQ-010 In IDLE, a data request SHALL win: IDLE->DACC if dREN|dWEN, else IDLE->IACC if iREN, else stay.
REQ-011 The winner's address, direction and store data SHALL be latched on the IDLE transition; RAM outputs SHALL be driven from the latches only, first in the cycle after the request was sampled.
REQ-012 In IDLE, RAM outputs SHALL be 0 and ramREN=ramWEN=0.
REQ-013 When ramstate==ACCESS in IACC, iwait SHALL be 0 and iload=ramload combinationally that cycle; next state IDLE.
REQ-014 When ramstate==ACCESS in DACC, dwait SHALL be 0 and dload=ramload combinationally that cycle; next state IDLE.
REQ-015 iwait and dwait SHALL be 1 in every other cycle; iload/dload SHALL be 0 when their wait is 1.
REQ-016 ramstate BUSY, FREE or ERROR SHALL hold the current state and outputs (retry; ERROR is not reported).
REQ-017 If the granted requester deasserts its request before ACCESS, the transaction SHALL abort: next state IDLE, no wait pulse.
REQ-018 If both dREN and dWEN are set, write SHALL win: ramWEN=1, ramREN=0.
REQ-019 Minimum latency request-to-wait-low SHALL be 2 cycles; back-to-back grants SHALL pass through one IDLE cycle.

Reset
REQ-020 On nRST low, state SHALL be IDLE, latches and starvation counter 0, iwait=dwait=1, all other outputs 0, regardless of an in-flight access.
REQ-021 After nRST rises, the first grant SHALL occur no earlier than the first rising edge.

Configuration
REQ-022 With ARB_STARVE_GUARD_EN defined, a counter SHALL increment on each completed data access while iREN=1, clear on each completed instruction access or iREN=0, and when it equals STARVE_MAX, IDLE SHALL grant IACC ahead of a pending data request.
REQ-023 Without ARB_STARVE_GUARD_EN, no counter SHALL exist and data priority SHALL be absolute.

Structure
REQ-024 The ramstate encoding and the FSM state enum SHALL live in cpu_types_pkg.
REQ-025 The starvation counter SHALL be sub-module arb_starve_counter, instantiated only under ARB_STARVE_GUARD_EN.
REQ-026 The block SHALL be 120-400 lines of RTL, with no other sub-modules.

Verification
REQ-027 iREN=1, iaddr=0x40, RAM ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> iwait low exactly once, iload=0xDEADBEEF.
REQ-028 iREN=dREN=1 simultaneously, daddr=0x100 -> DACC first (ramaddr=0x100), IDLE, then IACC.
REQ-029 dWEN=1, daddr=0x200, dstore=0x12345678 -> ramWEN=1, ramstore=0x12345678, dwait low on ACCESS, ramREN=0.
REQ-030 Grant DACC, drop dREN during BUSY -> return to IDLE, dwait never low, RAM outputs 0 next cycle.
REQ-031 nRST asserted mid-DACC -> all outputs at reset values immediately, IACC granted cleanly after release.
REQ-032 With ARB_STARVE_GUARD_EN, STARVE_MAX=4, dREN and iREN held -> 4 data accesses, then 1 instruction access, repeating.
